// File: rtl/core_pkg.sv
// Shared encodings, register constants and FSM state type for multicycle_core.
package core_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_HALT = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [4:0] ZERO = 5'd0;
  localparam logic [4:0] RA   = 5'd31;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/core_regfile.sv
// 32x32 GPR file: two async operand reads, one async debug read, one sync write; r0 reads 0.
module core_regfile
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  ra3,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] rd3,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [0:31];

  // NOTE: this array is flops, not a RAM macro, so it can and must clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != ZERO) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == ZERO) ? '0 : regs[ra1];
  assign rd2 = (ra2 == ZERO) ? '0 : regs[ra2];
  assign rd3 = (ra3 == ZERO) ? '0 : regs[ra3];

endmodule

// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencing with a req/ack data port.
// Define MULTICYCLE_PERF_CNT_EN to expose cycle/retired counters on dbg_sel=0.
module multicycle_core
  import core_pkg::*;
#(
  parameter int          IMEM_AW  = 10,
  parameter int          DMEM_AW  = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] i_addr,
  input  logic [31:0]        i_data,
  output logic               d_req,
  output logic               d_we,
  output logic [DMEM_AW-1:0] d_addr,
  output logic [31:0]        d_wdata,
  input  logic               d_ack,
  input  logic [31:0]        d_rdata,
  input  logic [4:0]         dbg_sel,
  output logic [31:0]        dbg_data,
  output logic               halted
);

  state_t             state;
  logic [IMEM_AW-1:0] pc, pc_plus1, next_pc;
  logic [31:0]        ir, op_a, op_b, mdr;
  logic [31:0]        rf_a, rf_b, rf_dbg;
  logic               rf_we;
  logic [4:0]         rf_wa;
  logic [31:0]        rf_wd;
  logic               ex_we, ex_mem, ex_halt;
  logic [4:0]         ex_wa;
  logic [31:0]        ex_wd;
  logic [5:0]         opcode, funct;
  logic [4:0]         rs, rt, rd;
  logic [31:0]        imm_sext, ea;
  logic               unused_ea;

  assign opcode    = ir[31:26];
  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign funct     = ir[5:0];
  assign imm_sext  = sext16(ir[15:0]);
  assign ea        = op_a + imm_sext;
  assign unused_ea = ^{ea[31:DMEM_AW+2], ea[1:0], rs};
  assign pc_plus1  = pc + IMEM_AW'(1);
  assign i_addr    = pc;

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    ex_we   = 1'b0;
    ex_wa   = rd;
    ex_wd   = '0;
    ex_mem  = 1'b0;
    ex_halt = 1'b0;
    next_pc = pc_plus1;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_ADD: begin ex_we = 1'b1; ex_wd = op_a + op_b; end
          FN_SUB: begin ex_we = 1'b1; ex_wd = op_a - op_b; end
          FN_AND: begin ex_we = 1'b1; ex_wd = op_a & op_b; end
          FN_OR:  begin ex_we = 1'b1; ex_wd = op_a | op_b; end
          FN_SLT: begin ex_we = 1'b1; ex_wd = {31'b0, $signed(op_a) < $signed(op_b)}; end
          FN_JR:  next_pc = op_a[IMEM_AW-1:0];
          FN_HALT: begin ex_halt = 1'b1; next_pc = pc; end
          default: ;
        endcase
      end
      OP_ADDI: begin ex_we = 1'b1; ex_wa = rt; ex_wd = op_a + imm_sext; end
      OP_SLTI: begin ex_we = 1'b1; ex_wa = rt; ex_wd = {31'b0, $signed(op_a) < $signed(imm_sext)}; end
      OP_BEQ:  if (op_a == op_b) next_pc = pc_plus1 + imm_sext[IMEM_AW-1:0];
      OP_BNE:  if (op_a != op_b) next_pc = pc_plus1 + imm_sext[IMEM_AW-1:0];
      OP_J:    next_pc = ir[IMEM_AW-1:0];
      OP_JAL: begin
        next_pc = ir[IMEM_AW-1:0];
        ex_we   = 1'b1;
        ex_wa   = RA;
        ex_wd   = 32'(pc_plus1);
      end
      OP_LW, OP_SW: ex_mem = 1'b1;
      default: ;
    endcase
  end

  assign rf_we = (state == EXEC && ex_we) || (state == WB);
  assign rf_wa = (state == WB) ? rt  : ex_wa;
  assign rf_wd = (state == WB) ? mdr : ex_wd;

  // Operand ports are addressed from i_data so DECODE can latch operands alongside ir.
  core_regfile u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (i_data[25:21]),
    .ra2 (i_data[20:16]),
    .ra3 (dbg_sel),
    .rd1 (rf_a),
    .rd2 (rf_b),
    .rd3 (rf_dbg),
    .we  (rf_we),
    .wa  (rf_wa),
    .wd  (rf_wd)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= IMEM_AW'(RESET_PC);
      ir      <= '0;
      op_a    <= '0;
      op_b    <= '0;
      mdr     <= '0;
      d_req   <= 1'b0;
      d_we    <= 1'b0;
      d_addr  <= '0;
      d_wdata <= '0;
      halted  <= 1'b0;
    end else begin
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          ir    <= i_data;
          op_a  <= rf_a;
          op_b  <= rf_b;
          state <= EXEC;
        end
        EXEC: begin
          pc <= next_pc;
          if (ex_halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (ex_mem) begin
            state   <= MEM;
            d_req   <= 1'b1;
            d_we    <= (opcode == OP_SW);
            d_addr  <= ea[DMEM_AW+1:2];
            d_wdata <= op_b;
          end else begin
            state <= FETCH;
          end
        end
        MEM: if (d_ack) begin
          d_req <= 1'b0;
          d_we  <= 1'b0;
          mdr   <= d_rdata;
          state <= d_we ? FETCH : WB;
        end
        WB:      state <= FETCH;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycle_cnt, retired_cnt;
  logic        retire;

  // An instruction retires on the edge that returns the FSM to FETCH.
  assign retire = (state == EXEC && !ex_mem && !ex_halt) ||
                  (state == MEM && d_ack && d_we) || (state == WB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (!halted) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) retired_cnt <= retired_cnt + 32'd1;
    end
  end

  assign dbg_data = (dbg_sel != ZERO) ? rf_dbg : (halted ? retired_cnt : cycle_cnt);
`else
  assign dbg_data = rf_dbg;
`endif

endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: ROM and req/ack memory models, queued expectations
// popped by a monitor on each data access and on halt / dump requests.
`timescale 1ns/1ps
module tb_multicycle_core;
  import core_pkg::*;

  localparam int IMEM_AW = 10;
  localparam int DMEM_AW = 16;
`ifdef MULTICYCLE_PERF_CNT_EN
  localparam logic [31:0] PERF_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] PERF_MASK = 32'h0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [IMEM_AW-1:0] i_addr;
  logic [31:0]        i_data = '0;
  logic               d_req, d_we;
  logic [DMEM_AW-1:0] d_addr;
  logic [31:0]        d_wdata;
  logic               d_ack = 1'b0;
  logic [31:0]        d_rdata = '0;
  logic [4:0]         dbg_sel = '0;
  logic [31:0]        dbg_data;
  logic               halted;

  multicycle_core #(.IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .halted(halted)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [31:0]        wdata;
    int                 cycles;
  } mem_exp_t;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] val;
  } reg_exp_t;

  mem_exp_t    mem_q[$];
  reg_exp_t    reg_q[$];
  int          checks = 0;
  int          failures = 0;
  int          dump_req = 0;
  int          dump_done = 0;
  int          dumps_expected = 0;
  int          ack_wait = 0;
  logic [31:0] rom [0:1023];
  bit   [31:0] dmem [0:255];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {OP_SPECIAL, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic exp_reg(input logic [4:0] idx, input logic [31:0] val);
    reg_exp_t e;
    e.idx = idx;
    e.val = val;
    reg_q.push_back(e);
  endtask

  task automatic exp_mem(input logic we, input logic [DMEM_AW-1:0] addr,
                         input logic [31:0] wdata, input int cycles);
    mem_exp_t e;
    e.we = we;
    e.addr = addr;
    e.wdata = wdata;
    e.cycles = cycles;
    mem_q.push_back(e);
  endtask

  // Instruction ROM: word appears one cycle after its address.
  initial forever begin
    @(posedge clk);
    #1 i_data = rom[i_addr];
  end

  // Data memory: acks after ack_wait idle MEM cycles.
  initial begin : dmem_model
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (d_req && !rst) begin
        if (cnt == ack_wait) begin
          d_ack = 1'b1;
          if (d_we) dmem[d_addr[7:0]] = d_wdata;
          else      d_rdata = dmem[d_addr[7:0]];
          cnt = 0;
        end else begin
          d_ack = 1'b0;
          cnt++;
        end
      end else begin
        d_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: pops memory expectations on each acked access, register expectations on halt/dump.
  initial begin : monitor
    int       req_cycles;
    int       seen_dump;
    logic     halted_q;
    mem_exp_t m;
    reg_exp_t r;
    req_cycles = 0;
    seen_dump = 0;
    halted_q = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        req_cycles = 0;
      end else begin
        if (d_req) req_cycles++;
        if (d_req && d_ack) begin
          check("mem access expected", 32'(mem_q.size() > 0), 32'd1);
          if (mem_q.size() > 0) begin
            m = mem_q.pop_front();
            check("mem d_we", 32'(d_we), 32'(m.we));
            check("mem d_addr", 32'(d_addr), 32'(m.addr));
            if (m.we) check("mem d_wdata", d_wdata, m.wdata);
            check("mem d_req cycles", 32'(req_cycles), 32'(m.cycles));
          end
          req_cycles = 0;
        end
      end
      if ((halted && !halted_q) || dump_req != seen_dump) begin
        seen_dump = dump_req;
        while (reg_q.size() > 0) begin
          r = reg_q.pop_front();
          dbg_sel = r.idx;
          #1 check($sformatf("dbg r%0d", r.idx), dbg_data, r.val);
        end
        dump_done++;
      end
      halted_q = halted;
    end
  end

  task automatic hold_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_dump(input string name);
    dumps_expected++;
    for (int i = 0; i < 600 && dump_done < dumps_expected; i++) @(negedge clk);
    check({name, " reached halt/dump"}, 32'(dump_done >= dumps_expected), 32'd1);
    check({name, " mem queue drained"}, 32'(mem_q.size()), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state.
    hold_reset();
    #1;
    check("rst d_req", 32'(d_req), 32'd0);
    check("rst d_we", 32'(d_we), 32'd0);
    check("rst d_addr", 32'(d_addr), 32'd0);
    check("rst d_wdata", d_wdata, 32'd0);
    check("rst halted", 32'(halted), 32'd0);
    check("rst i_addr", 32'(i_addr), 32'd0);

    // T1: ALU sequence and halt latency.
    rom[0] = enc_i(OP_ADDI, 5'd0, 5'd9, 16'd5);
    rom[1] = enc_i(OP_ADDI, 5'd0, 5'd10, 16'hFFFD);
    rom[2] = enc_r(FN_ADD, 5'd9, 5'd10, 5'd11);
    rom[3] = 32'h0;
    exp_reg(5'd9, 32'd5);
    exp_reg(5'd10, 32'hFFFF_FFFD);
    exp_reg(5'd11, 32'd2);
    exp_reg(5'd0, 32'd3 & PERF_MASK);
    release_reset();
    repeat (11) @(posedge clk);
    #1 check("t1 halted after 11", 32'(halted), 32'd0);
    @(posedge clk);
    #1 check("t1 halted after 12", 32'(halted), 32'd1);
    wait_dump("t1");
    check("t1 i_addr", 32'(i_addr), 32'd3);

    // T2: SW with 3 wait cycles, then LW with unaligned ea.
    hold_reset();
    ack_wait = 3;
    rom[0] = enc_i(OP_ADDI, 5'd0, 5'd9, 16'd5);
    rom[1] = enc_i(OP_ADDI, 5'd0, 5'd8, 16'h0010);
    rom[2] = enc_i(OP_SW, 5'd8, 5'd9, 16'd0);
    rom[3] = enc_i(OP_LW, 5'd8, 5'd12, 16'd3);
    exp_mem(1'b1, 16'd4, 32'd5, 4);
    exp_mem(1'b0, 16'd4, 32'd0, 4);
    exp_reg(5'd12, 32'd5);
    exp_reg(5'd0, 32'd4 & PERF_MASK);
    release_reset();
    wait_dump("t2");
    check("t2 i_addr", 32'(i_addr), 32'd4);

    // T3: BNE counting loop.
    hold_reset();
    rom[0] = enc_i(OP_ADDI, 5'd0, 5'd10, 16'd4);
    rom[1] = enc_i(OP_ADDI, 5'd9, 5'd9, 16'd1);
    rom[2] = enc_i(OP_BNE, 5'd9, 5'd10, 16'hFFFE);
    exp_reg(5'd9, 32'd4);
    exp_reg(5'd0, 32'd9 & PERF_MASK);
    release_reset();
    wait_dump("t3");
    check("t3 i_addr", 32'(i_addr), 32'd3);

    // T4: J, JAL and JR return.
    hold_reset();
    rom[0]  = enc_j(OP_J, 26'd7);
    rom[7]  = enc_j(OP_JAL, 26'd20);
    rom[8]  = enc_i(OP_ADDI, 5'd0, 5'd2, 16'h0055);
    rom[20] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'h0011);
    rom[21] = enc_r(FN_JR, 5'd31, 5'd0, 5'd0);
    exp_reg(5'd31, 32'd8);
    exp_reg(5'd1, 32'h11);
    exp_reg(5'd2, 32'h55);
    exp_reg(5'd0, 32'd5 & PERF_MASK);
    release_reset();
    wait_dump("t4");
    check("t4 i_addr", 32'(i_addr), 32'd9);

    // T5: r0 write, overflow wrap, signed compares, BEQ, unknown opcode, zero-wait load.
    hold_reset();
    ack_wait = 0;
    dmem[8] = 32'h7FFF_FFFF;
    rom[0]  = enc_i(OP_ADDI, 5'd0, 5'd0, 16'd7);
    rom[1]  = enc_r(FN_ADD, 5'd0, 5'd0, 5'd1);
    rom[2]  = enc_i(OP_LW, 5'd0, 5'd3, 16'h0020);
    rom[3]  = enc_i(OP_ADDI, 5'd3, 5'd4, 16'd1);
    rom[4]  = enc_r(FN_SLT, 5'd4, 5'd3, 5'd5);
    rom[5]  = enc_i(OP_SLTI, 5'd3, 5'd6, 16'hFFFF);
    rom[6]  = enc_r(FN_SUB, 5'd4, 5'd3, 5'd7);
    rom[7]  = enc_r(FN_AND, 5'd3, 5'd4, 5'd8);
    rom[8]  = enc_r(FN_OR, 5'd3, 5'd4, 5'd13);
    rom[9]  = enc_i(OP_BEQ, 5'd8, 5'd0, 16'd1);
    rom[10] = enc_i(OP_ADDI, 5'd0, 5'd14, 16'd1);
    rom[11] = enc_i(6'h3F, 5'd0, 5'd15, 16'd1);
    exp_mem(1'b0, 16'd8, 32'd0, 1);
    exp_reg(5'd1, 32'd0);
    exp_reg(5'd3, 32'h7FFF_FFFF);
    exp_reg(5'd4, 32'h8000_0000);
    exp_reg(5'd5, 32'd1);
    exp_reg(5'd6, 32'd0);
    exp_reg(5'd7, 32'd1);
    exp_reg(5'd8, 32'd0);
    exp_reg(5'd13, 32'hFFFF_FFFF);
    exp_reg(5'd14, 32'd0);
    exp_reg(5'd15, 32'd0);
    exp_reg(5'd0, 32'd11 & PERF_MASK);
    release_reset();
    wait_dump("t5");
    check("t5 i_addr", 32'(i_addr), 32'd12);

    // T6: reset asserted during a MEM wait.
    hold_reset();
    ack_wait = 1000;
    rom[0] = enc_i(OP_ADDI, 5'd0, 5'd9, 16'd5);
    rom[1] = enc_i(OP_SW, 5'd0, 5'd9, 16'h0040);
    release_reset();
    for (int i = 0; i < 50 && !d_req; i++) @(negedge clk);
    check("t6 d_req raised", 32'(d_req), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6 d_req drop", 32'(d_req), 32'd0);
    check("t6 d_we drop", 32'(d_we), 32'd0);
    check("t6 i_addr", 32'(i_addr), 32'd0);
    for (int i = 0; i < 32; i++) exp_reg(5'(i), 32'd0);
    dump_req++;
    wait_dump("t6");
    check("t6 store not performed", dmem[16], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
